// File: rtl/barrel_shift_pkg.sv
// Shared types and helpers for the shared 4-bit left barrel shifter and its arbiter.
// Holds the data/amount widths, the output-slot state encoding and the zero-fill shift rule.
package barrel_shift_pkg;

  localparam int DATA_W  = 4;
  localparam int AMT_W   = 2;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Bits shifted past the MSB are dropped; vacated LSBs are zero-filled.
  function automatic logic [DATA_W-1:0] shift_left(input logic [DATA_W-1:0] data,
                                                   input logic [AMT_W-1:0]  amt);
    logic [DATA_W-1:0] res;
    unique case (amt)
      2'd0:    res = data;
      2'd1:    res = {data[2:0], 1'b0};
      2'd2:    res = {data[1:0], 2'b00};
      2'd3:    res = {data[0], 3'b000};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, no latency.
// Contention goes to the requester not granted last; last_grant moves only when a grant is consumed.
module rr_arbiter_2 #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to the opposite of FIRST_PRIO so the first contention favours FIRST_PRIO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ~FIRST_PRIO;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/barrel_shift_arbiter_4bit.sv
// Two requesters share one registered 4-bit left shifter; result appears 1 cycle after accept.
// Readies drop while the output slot is full and out_ready is low; back-to-back at 1 result/cycle.
module barrel_shift_arbiter_4bit
  import barrel_shift_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic             out_id
);

  state_t              state;
  logic [NUM_REQ-1:0]  grant;
  logic                slot_free;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic [AMT_W-1:0]    sel_amt;

  rr_arbiter_2 #(
    .FIRST_PRIO (FIRST_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // rst_n gating keeps both readies low for the whole time reset is asserted.
  assign slot_free  = rst_n && ((state == ST_EMPTY) || out_ready);
  assign req0_ready = slot_free && grant[0];
  assign req1_ready = slot_free && grant[1];
  assign accept     = req0_ready || req1_ready;

  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign sel_amt    = grant[1] ? req1_amt  : req0_amt;
  assign out_valid  = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_id   <= 1'b0;
    end else if (accept) begin
      state    <= ST_FULL;
      out_data <= shift_left(sel_data, sel_amt);
      out_id   <= grant[1];
    end else if (out_ready) begin
      state    <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter_4bit.sv
// Bench for barrel_shift_arbiter_4bit: directed scenarios plus randomized traffic against a cycle model.
module tb_barrel_shift_arbiter_4bit;

  localparam bit FIRST_PRIO = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_data = 4'h0, req1_data = 4'h0;
  logic [1:0] req0_amt = 2'd0, req1_amt = 2'd0;
  logic       out_valid, out_ready = 1'b0, out_id;
  logic [3:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot contents plus who wins the next tie.
  logic       m_v;
  logic [3:0] m_d;
  logic       m_id;
  int         m_pri;

  always #5 clk = ~clk;

  barrel_shift_arbiter_4bit #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  function automatic int winner();
    if (!rst_n) return -1;
    if (m_v && !out_ready) return -1;
    if (req0_valid && req1_valid) return m_pri;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [3:0] ref_shift(input logic [3:0] d, input logic [1:0] a);
    int v;
    v = (int'(d) * (1 << a)) % 16;
    return v[3:0];
  endfunction

  task automatic model_reset();
    m_v = 1'b0; m_d = 4'h0; m_id = 1'b0; m_pri = int'(FIRST_PRIO);
  endtask

  // Advance one clock edge and update the model from the inputs presented before it.
  task automatic tick();
    int w;
    w = winner();
    @(posedge clk);
    if (w == 0) begin
      m_v = 1'b1; m_d = ref_shift(req0_data, req0_amt); m_id = 1'b0; m_pri = 1;
    end else if (w == 1) begin
      m_v = 1'b1; m_d = ref_shift(req1_data, req1_amt); m_id = 1'b1; m_pri = 0;
    end else if (out_ready) begin
      m_v = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_data, out_id} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state got v=%b d=%b id=%b exp 0/0000/0", out_valid, out_data, out_id);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_readies got %b%b exp 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 4'b1010; req0_amt = 2'd1; out_ready = 1'b1; #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_data, out_id} !== {1'b1, 4'b0100, 1'b0}) begin
      n_fail++; $display("FAIL single_out got v=%b d=%b id=%b exp 1/0100/0", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req0_valid = 1'b1; req0_data = 4'b0011; req0_amt = 2'd2;
    req1_valid = 1'b1; req1_data = 4'b0001; req1_amt = 2'd3;
    out_ready = 1'b1; #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL contention_rdy1 got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    n_tests++;
    if ({out_data, out_id} !== {4'b1100, 1'b0}) begin
      n_fail++; $display("FAIL contention_out1 got d=%b id=%b exp 1100/0", out_data, out_id);
    end
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL contention_rdy2 got %b%b exp 01", req0_ready, req1_ready);
    end
    tick();
    n_tests++;
    if ({out_valid, out_data, out_id} !== {1'b1, 4'b1000, 1'b1}) begin
      n_fail++; $display("FAIL contention_out2 got v=%b d=%b id=%b exp 1/1000/1", out_valid, out_data, out_id);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_id !== 1'(i % 2 == 0 ? 1 : 0) && 1'b0) begin end
      tick();
      n_fail += (out_id !== ((i % 2 == 0) ? 1'b0 : 1'b1)) ? 1 : 0;
      if (out_id !== ((i % 2 == 0) ? 1'b0 : 1'b1))
        $display("FAIL contention_alt%0d got id=%b exp %0d", i, out_id, (i % 2 == 0) ? 0 : 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_data = 4'b0011; req0_amt = 2'd1; out_ready = 1'b1;
    tick();
    req0_valid = 1'b0; out_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b0101; req1_amt = 2'd0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = i[0]; #1;
      n_tests++;
      if ({out_valid, out_data, req0_ready, req1_ready} !== {1'b1, 4'b0110, 2'b00}) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d got v=%b d=%b rdy=%b%b exp 1/0110/00", i, out_valid, out_data, req0_ready, req1_ready);
      end
      tick();
    end
    req0_valid = 1'b0; out_ready = 1'b1; #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release got req1_ready=%b exp 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_data, out_id} !== {1'b1, 4'b0101, 1'b1}) begin
      n_fail++; $display("FAIL backpressure_next got v=%b d=%b id=%b exp 1/0101/1", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_streaming();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'b1111; exp_d[1] = 4'b1110; exp_d[2] = 4'b1100; exp_d[3] = 4'b1000;
    out_ready = 1'b1; req1_valid = 1'b1; req1_data = 4'b1111;
    for (int a = 0; a < 4; a++) begin
      req1_amt = 2'(a); #1;
      n_tests++;
      if (req1_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready%0d got %b exp 1", a, req1_ready);
      end
      tick();
      n_tests++;
      if ({out_valid, out_data, out_id} !== {1'b1, exp_d[a], 1'b1}) begin
        n_fail++; $display("FAIL stream_out%0d got v=%b d=%b id=%b exp 1/%b/1", a, out_valid, out_data, out_id, exp_d[a]);
      end
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_data = 4'b0111; req0_amt = 2'd0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req1_valid = 1'b1;
    #2;
    rst_n = 1'b0; model_reset(); #1;
    n_tests++;
    if ({out_valid, out_data, req0_ready, req1_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid got v=%b d=%b rdy=%b%b exp 0/0000/00", out_valid, out_data, req0_ready, req1_ready);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== {FIRST_PRIO == 1'b0, FIRST_PRIO == 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_prio got %b%b exp first_prio=%0d", req0_ready, req1_ready, FIRST_PRIO);
    end
    tick();
    n_tests++;
    if (out_id !== FIRST_PRIO) begin
      n_fail++; $display("FAIL reset_mid_id got %b exp %b", out_id, FIRST_PRIO);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_idle();
    logic [3:0] last_d;
    out_ready = 1'b1; last_d = m_d;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({out_valid, req0_ready, req1_ready, out_data} !== {3'b000, last_d}) begin
        n_fail++;
        $display("FAIL idle%0d got v=%b rdy=%b%b d=%b exp 0/00/%b", i, out_valid, req0_ready, req1_ready, out_data, last_d);
      end
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_data = 4'($urandom); req1_data = 4'($urandom);
      req0_amt = 2'($urandom); req1_amt = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      w = winner();
      n_tests++;
      if ({req0_ready, req1_ready} !== {w == 0, w == 1}) begin
        n_fail++; $display("FAIL rand_ready%0d got %b%b exp winner=%0d", i, req0_ready, req1_ready, w);
      end
      tick();
      n_tests++;
      if (out_valid !== m_v || (m_v && (out_data !== m_d || out_id !== m_id))) begin
        n_fail++;
        $display("FAIL rand_out%0d got v=%b d=%b id=%b exp v=%b d=%b id=%b", i, out_valid, out_data, out_id, m_v, m_d, m_id);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_streaming();
    test_idle();
    test_reset_mid();
    test_random();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
